// File: rtl/mem_port_arbiter_if.sv
// Bus bundle for mem_port_arbiter.
// Contains the instruction-fetch port (I_*), the data load/store port (D_*) and the
// shared memory-controller port (M_*).
//   master : the environment side. It drives the requests and M_ReadData, and it
//            observes the acks, the read data and the shared-port outputs.
//   slave  : the arbiter side, which is the mirror image of master.
interface mem_port_arbiter_if;
    logic        I_Req;
    logic [31:0] I_Address;
    logic [31:0] I_ReadData;
    logic        I_Ack;

    logic        D_Req;
    logic        D_Write;
    logic [31:0] D_Address;
    logic [31:0] D_WriteData;
    logic [31:0] D_ReadData;
    logic        D_Ack;

    logic [31:0] M_Address;
    logic [31:0] M_WriteData;
    logic        M_WriteAssert;
    logic [31:0] M_ReadData;

    modport master (
        output I_Req, I_Address, D_Req, D_Write, D_Address, D_WriteData, M_ReadData,
        input  I_ReadData, I_Ack, D_ReadData, D_Ack, M_Address, M_WriteData, M_WriteAssert
    );

    modport slave (
        input  I_Req, I_Address, D_Req, D_Write, D_Address, D_WriteData, M_ReadData,
        output I_ReadData, I_Ack, D_ReadData, D_Ack, M_Address, M_WriteData, M_WriteAssert
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates an instruction-fetch port and a data load/store port onto one shared
// memory-controller port. Each access runs through the states IDLE, ISSUE, WAIT and
// back to IDLE. The data port normally wins contested arbitrations. The instruction
// port is forced to win once it has lost STARVE_LIMIT contested rounds in a row.
// Ports:
//   CoreClock : sole clock, rising edge.
//   Reset     : synchronous, active-high reset.
//   bus       : mem_port_arbiter_if.slave, which carries the I_*, D_* and M_* signals.
module mem_port_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input logic                CoreClock,
    input logic                Reset,
    mem_port_arbiter_if.slave  bus
);
    localparam int unsigned CntW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
    localparam logic [CntW-1:0] StarveMax = CntW'(STARVE_LIMIT);

    typedef enum logic [1:0] {StIdle, StIssue, StWait} state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] starve_q, starve_d;
    logic            owner_d_q, owner_d_d;    // 1: data port owns the access
    logic            write_q, write_d;
    logic [31:0]     addr_q, addr_d;
    logic [31:0]     wdata_q, wdata_d;
    logic            we_q, we_d;
    logic            i_ack_q, i_ack_d;
    logic            d_ack_q, d_ack_d;
    logic [31:0]     i_rdata_q, i_rdata_d;
    logic [31:0]     d_rdata_q, d_rdata_d;

    logic i_elig, d_elig, grant_i;

    always_comb begin
        state_d   = state_q;
        starve_d  = starve_q;
        owner_d_d = owner_d_q;
        write_d   = write_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        i_rdata_d = i_rdata_q;
        d_rdata_d = d_rdata_q;
        // Acks and the write strobe are single-cycle pulses, so they default low.
        we_d      = 1'b0;
        i_ack_d   = 1'b0;
        d_ack_d   = 1'b0;
        grant_i   = 1'b0;

        // A port is not eligible during its own ack cycle. This stops a held Req
        // from being granted a second time.
        i_elig = bus.I_Req && !i_ack_q;
        d_elig = bus.D_Req && !d_ack_q;

        case (state_q)
            StIdle: begin
                if (i_elig || d_elig) begin
                    grant_i = i_elig && (!d_elig || (starve_q == StarveMax));
                    if (grant_i) begin
                        owner_d_d = 1'b0;
                        addr_d    = bus.I_Address;
                        write_d   = 1'b0;
                        wdata_d   = '0;
                        starve_d  = '0;
                    end else begin
                        owner_d_d = 1'b1;
                        addr_d    = bus.D_Address;
                        write_d   = bus.D_Write;
                        wdata_d   = bus.D_WriteData;
                        we_d      = bus.D_Write;
                        // The instruction port is still eligible here, so it lost a
                        // contested round.
                        if (i_elig && (starve_q != StarveMax)) begin
                            starve_d = starve_q + CntW'(1);
                        end
                    end
                    state_d = StIssue;
                end
            end
            StIssue: state_d = StWait;
            StWait: begin
                state_d = StIdle;
                if (owner_d_q) begin
                    d_ack_d = 1'b1;
                    if (!write_q) begin
                        d_rdata_d = bus.M_ReadData;
                    end
                end else begin
                    i_ack_d   = 1'b1;
                    i_rdata_d = bus.M_ReadData;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge CoreClock) begin
        if (Reset) begin
            state_q   <= StIdle;
            starve_q  <= '0;
            owner_d_q <= 1'b0;
            write_q   <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            we_q      <= 1'b0;
            i_ack_q   <= 1'b0;
            d_ack_q   <= 1'b0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
        end else begin
            state_q   <= state_d;
            starve_q  <= starve_d;
            owner_d_q <= owner_d_d;
            write_q   <= write_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            we_q      <= we_d;
            i_ack_q   <= i_ack_d;
            d_ack_q   <= d_ack_d;
            i_rdata_q <= i_rdata_d;
            d_rdata_q <= d_rdata_d;
        end
    end

    assign bus.M_Address     = addr_q;
    assign bus.M_WriteData   = wdata_q;
    assign bus.M_WriteAssert = we_q;
    assign bus.I_Ack         = i_ack_q;
    assign bus.D_Ack         = d_ack_q;
    assign bus.I_ReadData    = i_rdata_q;
    assign bus.D_ReadData    = d_rdata_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter.
// A behavioural model tracks each in-flight access as a countdown of remaining cycles.
// A compare process checks every DUT output against that model on each falling edge.
// Directed sequences pin the model with literal expectations, and a randomized phase
// follows them.
module tb_mem_port_arbiter;
    localparam int Limit = 4;

    logic CoreClock = 1'b0;
    logic Reset     = 1'b1;
    always #5 CoreClock = ~CoreClock;

    mem_port_arbiter_if bus();

    mem_port_arbiter #(.STARVE_LIMIT(Limit)) dut (
        .CoreClock (CoreClock),
        .Reset     (Reset),
        .bus       (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model. Its state is updated on every rising edge from the inputs
    // as they stand at that edge.
    bit          model_valid = 0;
    bit          busy = 0, own_d = 0, wr = 0;
    int          left = 0, starve = 0;
    logic        ie, de, gi;
    logic        e_iack = 0, e_dack = 0, e_we = 0;
    logic [31:0] e_ird = 0, e_drd = 0, e_addr = 0, e_wd = 0;

    always @(posedge CoreClock) begin
        if (Reset) begin
            busy = 0; starve = 0; own_d = 0; wr = 0; left = 0;
            e_iack = 0; e_dack = 0; e_we = 0;
            e_ird = 0; e_drd = 0; e_addr = 0; e_wd = 0;
            model_valid = 1;
        end else if (model_valid) begin
            ie = bus.I_Req && !e_iack;
            de = bus.D_Req && !e_dack;
            e_iack = 0; e_dack = 0; e_we = 0;
            if (busy && left == 2) begin
                left = 1;
            end else if (busy) begin
                busy = 0;
                if (own_d) begin
                    e_dack = 1;
                    if (!wr) e_drd = bus.M_ReadData;
                end else begin
                    e_iack = 1;
                    e_ird  = bus.M_ReadData;
                end
            end else if (ie || de) begin
                gi = ie && (!de || starve == Limit);
                if (gi) begin
                    starve = 0; own_d = 0; wr = 0;
                    e_addr = bus.I_Address; e_wd = 0;
                end else begin
                    if (ie && starve < Limit) starve = starve + 1;
                    own_d = 1; wr = bus.D_Write;
                    e_addr = bus.D_Address; e_wd = bus.D_WriteData;
                end
                e_we = wr;
                busy = 1;
                left = 2;
            end
        end
    end

    always @(negedge CoreClock) begin
        if (model_valid) begin
            check("I_Ack", bus.I_Ack, e_iack);
            check("D_Ack", bus.D_Ack, e_dack);
            check("M_WriteAssert", bus.M_WriteAssert, e_we);
            check("M_Address", bus.M_Address, e_addr);
            check("M_WriteData", bus.M_WriteData, e_wd);
            check("I_ReadData", bus.I_ReadData, e_ird);
            check("D_ReadData", bus.D_ReadData, e_drd);
            check("ack_exclusive", bus.I_Ack & bus.D_Ack, 0);
        end
    end

    task automatic wait_ack(input bit is_d, output int cycles);
        cycles = 0;
        do begin
            @(negedge CoreClock);
            cycles++;
        end while (!(is_d ? bus.D_Ack : bus.I_Ack) && cycles < 20);
        check(is_d ? "D_Ack_seen" : "I_Ack_seen", is_d ? bus.D_Ack : bus.I_Ack, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", n_errors);
        $fatal(1, "watchdog");
    end

    int          cyc, n_strobe;
    logic [31:0] s_addr, s_wd;
    bit          won_i;
    int          acks[$];

    initial begin
        bus.I_Req = 0; bus.I_Address = 0;
        bus.D_Req = 0; bus.D_Write = 0; bus.D_Address = 0; bus.D_WriteData = 0;
        bus.M_ReadData = 0;
        repeat (3) @(negedge CoreClock);
        check("rst_I_Ack", bus.I_Ack, 0);
        check("rst_D_Ack", bus.D_Ack, 0);
        check("rst_M_WriteAssert", bus.M_WriteAssert, 0);
        check("rst_M_Address", bus.M_Address, 0);
        check("rst_M_WriteData", bus.M_WriteData, 0);
        check("rst_I_ReadData", bus.I_ReadData, 0);
        check("rst_D_ReadData", bus.D_ReadData, 0);
        Reset = 0;

        // Single fetch.
        @(negedge CoreClock);
        bus.I_Req = 1; bus.I_Address = 32'h100; bus.M_ReadData = 32'hDEADBEEF;
        wait_ack(0, cyc);
        check("fetch_latency", cyc, 3);
        check("fetch_data", bus.I_ReadData, 32'hDEADBEEF);
        check("fetch_addr", bus.M_Address, 32'h100);
        bus.I_Req = 0;
        @(negedge CoreClock);
        check("fetch_ack_pulse", bus.I_Ack, 0);

        // Load, so that the following store has a known D_ReadData to preserve.
        bus.D_Req = 1; bus.D_Write = 0; bus.D_Address = 32'h200; bus.M_ReadData = 32'hCAFEF00D;
        wait_ack(1, cyc);
        check("load_data", bus.D_ReadData, 32'hCAFEF00D);
        bus.D_Req = 0;
        @(negedge CoreClock);

        // Store.
        bus.D_Req = 1; bus.D_Write = 1; bus.D_Address = 32'h10040;
        bus.D_WriteData = 32'h12345678; bus.M_ReadData = 32'h0BADBEEF;
        n_strobe = 0; s_addr = 0; s_wd = 0;
        for (int c = 0; c < 20 && !bus.D_Ack; c++) begin
            @(negedge CoreClock);
            if (bus.M_WriteAssert) begin
                n_strobe++; s_addr = bus.M_Address; s_wd = bus.M_WriteData;
            end
        end
        check("store_ack", bus.D_Ack, 1);
        check("store_strobe_count", n_strobe, 1);
        check("store_addr", s_addr, 32'h10040);
        check("store_wdata", s_wd, 32'h12345678);
        check("store_keeps_rdata", bus.D_ReadData, 32'hCAFEF00D);
        bus.D_Req = 0; bus.D_Write = 0;
        @(negedge CoreClock);
        check("store_ack_pulse", bus.D_Ack, 0);

        // Idle: nothing moves and the shared address holds.
        for (int c = 0; c < 20; c++) begin
            @(negedge CoreClock);
            check("idle_we", bus.M_WriteAssert, 0);
            check("idle_acks", {bus.I_Ack, bus.D_Ack}, 0);
            check("idle_addr", bus.M_Address, 32'h10040);
        end

        // Contention: both requests are presented together from a quiet IDLE cycle,
        // so each round is a contested arbitration. The loser withdraws.
        for (int r = 0; r < 6; r++) begin
            @(negedge CoreClock);
            bus.I_Req = 1; bus.I_Address = 32'h1000 + r;
            bus.D_Req = 1; bus.D_Write = 0; bus.D_Address = 32'h2000 + r;
            @(negedge CoreClock);
            won_i = (bus.M_Address == 32'h1000 + r);
            check("contest_grant", bus.M_Address, (r == 4) ? 32'h1000 + r : 32'h2000 + r);
            if (won_i) bus.D_Req = 0; else bus.I_Req = 0;
            wait_ack(!won_i, cyc);
            bus.I_Req = 0; bus.D_Req = 0;
            @(negedge CoreClock);
        end

        // Back-to-back: D_Req stays high with a fresh address after each ack.
        @(negedge CoreClock);
        bus.D_Req = 1; bus.D_Write = 0; bus.D_Address = 32'h3000;
        for (int c = 1; c <= 16; c++) begin
            @(negedge CoreClock);
            if (bus.D_Ack) begin
                acks.push_back(c);
                bus.D_Address = bus.D_Address + 4;
            end
        end
        bus.D_Req = 0;
        check("b2b_count", acks.size(), 4);
        if (acks.size() == 4) begin
            check("b2b_first", acks[0], 3);
            check("b2b_gap1", acks[1] - acks[0], 4);
            check("b2b_gap2", acks[2] - acks[1], 4);
            check("b2b_gap3", acks[3] - acks[2], 4);
        end
        repeat (2) @(negedge CoreClock);

        // Reset during the ISSUE cycle of a store.
        bus.D_Req = 1; bus.D_Write = 1; bus.D_Address = 32'h4000; bus.D_WriteData = 32'hA5A5A5A5;
        @(negedge CoreClock);
        check("rst_issue_strobe", bus.M_WriteAssert, 1);
        Reset = 1; bus.D_Req = 0; bus.D_Write = 0;
        @(negedge CoreClock);
        check("rst_issue_we", bus.M_WriteAssert, 0);
        check("rst_issue_addr", bus.M_Address, 0);
        check("rst_issue_wd", bus.M_WriteData, 0);
        check("rst_issue_rd", bus.I_ReadData | bus.D_ReadData, 0);
        Reset = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge CoreClock);
            check("rst_issue_no_ack", {bus.I_Ack, bus.D_Ack, bus.M_WriteAssert}, 0);
        end

        // Randomized traffic, including early Req drops and occasional resets.
        for (int c = 0; c < 3000; c++) begin
            @(negedge CoreClock);
            bus.M_ReadData = $urandom;
            Reset = ($urandom_range(0, 399) == 0);
            if (bus.I_Ack) begin
                if ($urandom_range(0, 3) == 0) bus.I_Address = $urandom;
                else bus.I_Req = 0;
            end else if (!bus.I_Req) begin
                if ($urandom_range(0, 2) == 0) begin
                    bus.I_Req = 1; bus.I_Address = $urandom;
                end
            end else if ($urandom_range(0, 63) == 0) begin
                bus.I_Req = 0;
            end
            if (bus.D_Ack) begin
                if ($urandom_range(0, 3) == 0) begin
                    bus.D_Address = $urandom; bus.D_WriteData = $urandom;
                    bus.D_Write = $urandom_range(0, 1);
                end else begin
                    bus.D_Req = 0;
                end
            end else if (!bus.D_Req) begin
                if ($urandom_range(0, 2) == 0) begin
                    bus.D_Req = 1; bus.D_Address = $urandom; bus.D_WriteData = $urandom;
                    bus.D_Write = $urandom_range(0, 1);
                end
            end else if ($urandom_range(0, 63) == 0) begin
                bus.D_Req = 0;
            end
        end
        Reset = 0; bus.I_Req = 0; bus.D_Req = 0;
        repeat (6) @(negedge CoreClock);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4: max consecutive contested arbitrations the instruction port may lose before it is forced to win.
REQ-002 SHALL have port CoreClock  in  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port Reset  in  1  synchronous, active-high reset.
REQ-004 SHALL have port I_Req  in  1  instruction-fetch read request, held high until I_Ack.
REQ-005 SHALL have port I_Address  in  32  instruction byte address, stable while I_Req high.
REQ-006 SHALL have port I_ReadData  out  32  registered fetch data, valid while I_Ack high.
REQ-007 SHALL have port I_Ack  out  1  one-cycle completion pulse for the instruction port.
REQ-008 SHALL have port D_Req  in  1  data load/store request, held high until D_Ack.
REQ-009 SHALL have port D_Write  in  1  1 = store, 0 = load; stable while D_Req high.
REQ-010 SHALL have port D_Address  in  32  data byte address, stable while D_Req high.
REQ-011 SHALL have port D_WriteData  in  32  store data, stable while D_Req high.
REQ-012 SHALL have port D_ReadData  out  32  registered load data, valid while D_Ack high.
REQ-013 SHALL have port D_Ack  out  1  one-cycle completion pulse for the data port.
REQ-014 SHALL have port M_Address  out  32  address to the shared memory controller port.
REQ-015 SHALL have port M_WriteData  out  32  write data to the shared port.
REQ-016 SHALL have port M_WriteAssert  out  1  write strobe to the shared port.
REQ-017 SHALL have port M_ReadData  in  32  read data; valid one cycle after M_Address is presented.

Function
REQ-018 SHALL implement FSM states IDLE, ISSUE, WAIT; every access takes IDLE->ISSUE->WAIT->IDLE.
REQ-019 In IDLE, a port is eligible if its Req is high and its Ack is low in that cycle; if none is eligible, the FSM stays in IDLE.
REQ-020 Arbitration in IDLE: D wins unless I is eligible and StarveCount == STARVE_LIMIT, in which case I wins; if only one port is eligible, it wins.
REQ-021 StarveCount (width clog2(STARVE_LIMIT+1)) SHALL increment on each IDLE arbitration where both ports are eligible and D wins, saturating at STARVE_LIMIT; it clears to 0 whenever I wins.
REQ-022 On the winning edge, SHALL latch Owner, address, write flag (0 for I), and write data into registers, then enter ISSUE.
REQ-023 M_Address and M_WriteData SHALL be driven from the latched registers at all times, and SHALL hold their last value in IDLE.
REQ-024 M_WriteAssert SHALL be 1 only in ISSUE when the latched write flag is 1: exactly one cycle per store.
REQ-025 At the edge ending WAIT, SHALL capture M_ReadData into the Owner's ReadData register (loads and fetches only), set the Owner's Ack to 1 for the next cycle, and return to IDLE.
REQ-026 A store SHALL NOT modify D_ReadData; the non-owner's ReadData and Ack SHALL be unchanged.
REQ-027 Ack SHALL be high for exactly one cycle; latency from the Req-sampling edge to Ack high is 3 cycles; peak throughput is one access per 3 cycles.
REQ-028 I_Ack and D_Ack SHALL never be high in the same cycle.
REQ-029 Req deasserted before Ack (protocol violation) SHALL NOT abort an in-flight access; it completes and acks.
REQ-030 Address bits SHALL pass unmodified; alignment handling is out of scope.

Reset
REQ-031 Reset high at an edge SHALL force: state IDLE, StarveCount 0, I_Ack 0, D_Ack 0, M_WriteAssert 0, I_ReadData/D_ReadData/M_Address/M_WriteData 0.
REQ-032 Reset during ISSUE or WAIT SHALL drop the in-flight access with no Ack and no further write strobe.
REQ-033 Reset SHALL take priority over every other event in the same cycle.

Verification
REQ-034 Single fetch: I_Req=1, I_Address=0x100, M_ReadData=0xDEADBEEF in WAIT -> I_Ack high 3 cycles after sampling, I_ReadData=0xDEADBEEF.
REQ-035 Store: D_Req=1, D_Write=1, D_Address=0x10040, D_WriteData=0x12345678 -> M_WriteAssert high exactly 1 cycle with M_Address=0x10040, D_Ack pulses once, D_ReadData unchanged.
REQ-036 Contention: I_Req and D_Req both held continuously, STARVE_LIMIT=4 -> grant order D,D,D,D,I, repeating; StarveCount returns to 0 after each I grant.
REQ-037 Back-to-back: D_Req held with a new request issued right after D_Ack -> no double grant during the Ack cycle; next grant on the following IDLE cycle.
REQ-038 Reset asserted in ISSUE of a store -> M_WriteAssert 0 from the next cycle, no Ack, state IDLE, all outputs 0.
REQ-039 Idle: both Req low for 20 cycles -> M_WriteAssert, I_Ack and D_Ack stay 0, and M_Address holds its value.
